// File: rtl/noc_packet_recorder.sv
// noc_packet_recorder
//   Passive packet recorder for one NoC link. It watches link transfers
//   (link_valid & link_ready) and never drives the link. For each packet it
//   builds an 80-bit record {timestamp, length, header}, where timestamp is
//   the free-running cycle counter value at the header transfer. Each record
//   is queued in a small FIFO for a downstream consumer.
//
//   Parameters
//     FIFO_DEPTH   record FIFO depth; must be a power of two and at least 2
//     FLIT_WIDTH   width of the snooped flit payload
//
//   Ports
//     clk, rst_n        block clock; asynchronous active-low reset
//     enable            recording enable, sampled at the header transfer only
//     link_flit         snooped flit payload
//     link_last         snooped last-flit marker
//     link_valid        snooped link valid
//     link_ready        snooped link ready
//     rec_data          oldest queued record, or zero when the FIFO is empty
//     rec_valid         FIFO not empty
//     rec_ready         consumer accepts the head record
//     overflow_cnt      saturating count of dropped records; this port exists
//                       only when NOC_PACKET_RECORDER_OVERFLOW_CNT_EN is defined
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a header; skip_q set = discarding an unrecorded packet
//   S_IN_PKT | header accepted, counting flits until link_last
module noc_packet_recorder #(
   parameter int FIFO_DEPTH = 8,
   parameter int FLIT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [FLIT_WIDTH-1:0] link_flit,
   input  logic                  link_last,
   input  logic                  link_valid,
   input  logic                  link_ready,
   output logic [79:0]           rec_data,
   output logic                  rec_valid,
   input  logic                  rec_ready
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
   ,
   output logic [15:0]           overflow_cnt
`endif
);

   localparam int             AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_IN_PKT} state_t;

   state_t        state_q, state_d;
   logic          skip_q, skip_d;
   logic [31:0]   ts_q;
   logic [31:0]   hdr_q, hdr_d;
   logic [31:0]   tcap_q, tcap_d;
   logic [15:0]   len_q, len_d, len_inc;
   logic [31:0]   flit_hdr;
   logic          xfer;
   logic          commit;
   logic [79:0]   commit_rec;

   logic [79:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop;

   generate
      if (FLIT_WIDTH >= 32) begin : g_hdr_trunc
         assign flit_hdr = link_flit[31:0];
      end else begin : g_hdr_zext
         assign flit_hdr = {{(32-FLIT_WIDTH){1'b0}}, link_flit};
      end
   endgenerate

   assign xfer = link_valid & link_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         skip_q  <= 1'b0;
         hdr_q   <= '0;
         tcap_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         hdr_q   <= hdr_d;
         tcap_q  <= tcap_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      skip_d     = skip_q;
      hdr_d      = hdr_q;
      tcap_d     = tcap_q;
      len_d      = len_q;
      commit     = 1'b0;
      commit_rec = '0;
      len_inc    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               if (skip_q) begin
                  if (link_last) skip_d = 1'b0;
               end else if (enable) begin
                  hdr_d  = flit_hdr;
                  tcap_d = ts_q;
                  len_d  = 16'd1;
                  if (link_last) begin
                     // single-flit packet commits straight from the live inputs
                     commit     = 1'b1;
                     commit_rec = {ts_q, 16'd1, flit_hdr};
                  end else begin
                     state_d = S_IN_PKT;
                  end
               end else if (!link_last) begin
                  skip_d = 1'b1;
               end
            end
         end
         S_IN_PKT: begin
            if (xfer) begin
               len_d = len_inc;
               if (link_last) begin
                  commit     = 1'b1;
                  commit_rec = {tcap_q, len_inc, hdr_q};
                  state_d    = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A pop frees the head slot in the same edge, so a commit into a full
   // FIFO is still accepted when the consumer is draining.
   assign full      = (count == DEPTH_CNT);
   assign rec_valid = (count != '0);
   assign pop       = rec_valid & rec_ready;
   assign push      = commit & (~full | pop);
   assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= commit_rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow_cnt <= '0;
      else if (commit && full && !pop && overflow_cnt != 16'hFFFF)
         overflow_cnt <= overflow_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_noc_packet_recorder.sv
module tb_noc_packet_recorder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [31:0] link_flit;
   logic        link_last;
   logic        link_valid;
   logic        link_ready;
   logic [79:0] rec_data;
   logic        rec_valid;
   logic        rec_ready;
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
   logic [15:0] overflow_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // reference model: packet-level view plus a queue of records
   int unsigned m_ts;
   bit          m_coll;
   bit          m_skip;
   logic [31:0] m_hdr;
   logic [31:0] m_start;
   int          m_len;
   int          m_drop;
   logic [79:0] m_q[$];

   noc_packet_recorder #(.FIFO_DEPTH(DEPTH), .FLIT_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .link_flit    (link_flit),
      .link_last    (link_last),
      .link_valid   (link_valid),
      .link_ready   (link_ready),
      .rec_data     (rec_data),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready)
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
      ,
      .overflow_cnt (overflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ts = 0; m_coll = 0; m_skip = 0; m_hdr = 0; m_start = 0; m_len = 0; m_drop = 0;
      m_q.delete();
   endtask

   task automatic model_edge();
      bit          commit;
      logic [79:0] rec;
      bit          pop;
      commit = 0;
      rec    = '0;
      pop    = (m_q.size() != 0) && rec_ready;
      if (link_valid && link_ready) begin
         if (m_coll) begin
            if (m_len < 65535) m_len++;
            if (link_last) begin
               commit = 1; m_coll = 0;
            end
         end else if (m_skip) begin
            if (link_last) m_skip = 0;
         end else if (enable) begin
            m_hdr = link_flit; m_start = m_ts; m_len = 1;
            if (link_last) commit = 1;
            else           m_coll = 1;
         end else if (!link_last) begin
            m_skip = 1;
         end
         if (commit) rec = {m_start, 16'(m_len), m_hdr};
      end
      if (pop) void'(m_q.pop_front());
      if (commit) begin
         if (m_q.size() < DEPTH) m_q.push_back(rec);
         else if (m_drop < 65535) m_drop++;
      end
      m_ts++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("valid", {79'd0, rec_valid}, {79'd0, m_q.size() != 0});
      check("data", rec_data, (m_q.size() != 0) ? m_q[0] : 80'd0);
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
      check("ovf", {64'd0, overflow_cnt}, 80'(m_drop));
`endif
   endtask

   task automatic drive(input bit v, input bit r, input bit l, input logic [31:0] f,
                        input bit en, input bit rr);
      link_valid = v; link_ready = r; link_last = l; link_flit = f;
      enable = en; rec_ready = rr;
      tick();
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 1, rr);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      link_valid = 0; link_ready = 0; link_last = 0; link_flit = 0; enable = 1; rec_ready = 0;
      #1;
      check("rst_valid", {79'd0, rec_valid}, 80'd0);
      check("rst_data", rec_data, 80'd0);
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
      check("rst_ovf", {64'd0, overflow_cnt}, 80'd0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      link_valid = 0; link_ready = 0; link_last = 0; link_flit = 0; enable = 1; rec_ready = 0;
      @(negedge clk);

      // 3-flit packet, header at timestamp 10, last at 14
      do_reset();
      idle(10, 0);
      drive(1, 1, 0, 32'hCAFE0001, 1, 0);
      drive(1, 1, 0, 32'h11111111, 1, 0);
      idle(2, 0);
      drive(1, 1, 1, 32'h22222222, 1, 0);
      check("pkt3_valid", {79'd0, rec_valid}, 80'd1);
      check("pkt3_rec", rec_data, {32'd10, 16'd3, 32'hCAFE0001});
      idle(1, 1);

      // single-flit packet at timestamp 5
      do_reset();
      idle(5, 0);
      drive(1, 1, 1, 32'h12, 1, 0);
      check("single_rec", rec_data, {32'd5, 16'd1, 32'h12});
      idle(1, 1);

      // stalled flit counts once
      do_reset();
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 32'h77, 1, 0);
      drive(1, 1, 1, 32'h77, 1, 0);
      check("stall_rec", rec_data, {32'd4, 16'd1, 32'h77});

      // overflow: 10 commits into an 8-deep FIFO, then drain
      do_reset();
      for (int i = 0; i < 10; i++) drive(1, 1, 1, 32'h100 + i, 1, 0);
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
      check("ovf_two", {64'd0, overflow_cnt}, 80'd2);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_order", rec_data, {32'(i), 16'd1, 32'h100 + 32'(i)});
         idle(1, 1);
      end
      check("drain_empty", {79'd0, rec_valid}, 80'd0);

      // commit into full FIFO with simultaneous pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) drive(1, 1, 1, 32'h100 + i, 1, 0);
      drive(1, 1, 1, 32'h200, 1, 1);
`ifdef NOC_PACKET_RECORDER_OVERFLOW_CNT_EN
      check("full_pop_ovf", {64'd0, overflow_cnt}, 80'd0);
`endif
      for (int i = 1; i < DEPTH; i++) begin
         check("full_pop_order", rec_data, {32'(i), 16'd1, 32'h100 + 32'(i)});
         idle(1, 1);
      end
      check("full_pop_new", rec_data, {32'd8, 16'd1, 32'h200});
      idle(1, 1);
      check("full_pop_empty", {79'd0, rec_valid}, 80'd0);

      // disabled header skips its whole packet even if enable rises mid-packet
      do_reset();
      drive(1, 1, 0, 32'hAAAA0000, 0, 0);
      drive(1, 1, 0, 32'hAAAA0001, 1, 0);
      drive(1, 1, 0, 32'hAAAA0002, 1, 0);
      drive(1, 1, 1, 32'hAAAA0003, 1, 0);
      check("skip_none", {79'd0, rec_valid}, 80'd0);
      drive(1, 1, 0, 32'hBEEF, 1, 0);
      drive(1, 1, 1, 32'hBEEF0001, 0, 0);
      check("skip_second", rec_data, {32'd4, 16'd2, 32'hBEEF});

      // reset mid-packet: remaining flit becomes a fresh header
      idle(1, 1);
      drive(1, 1, 0, 32'hDEAD, 1, 0);
      drive(1, 1, 0, 32'hDEAD0001, 1, 0);
      do_reset();
      drive(1, 1, 1, 32'h5555, 1, 0);
      check("rst_mid_rec", rec_data, {32'd0, 16'd1, 32'h5555});

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(99) < 60, $urandom_range(99) < 70, $urandom_range(99) < 30,
               $urandom, $urandom_range(99) < 75,
               (i % 200 < 100) ? ($urandom_range(99) < 20) : ($urandom_range(99) < 70));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/noc_packet_recorder.md
NOC_PACKET_RECORDER -- requirements
Module: noc_packet_recorder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, is the record FIFO depth and SHALL be a power of two, at least 2.
REQ-002 Parameter FLIT_WIDTH, default 32, is the width of the snooped flit payload.
REQ-003 clk  input  1  the single block clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  recording enable; sampled only when a packet header is observed.
REQ-006 link_flit  input  FLIT_WIDTH  flit payload snooped from one NoC link.
REQ-007 link_last  input  1  last-flit marker snooped from the link.
REQ-008 link_valid  input  1  link valid, snooped.
REQ-009 link_ready  input  1  link ready, snooped; the block SHALL never drive the link.
REQ-010 rec_data  output  80  head record: {timestamp[31:0], length[15:0], header[31:0]}.
REQ-011 rec_valid  output  1  head record available.
REQ-012 rec_ready  input  1  consumer accepts the head record.
REQ-013 overflow_cnt  output  16  dropped-record count; present only under REQ-030.

Function
REQ-014 A flit transfer SHALL be defined as link_valid & link_ready in a cycle; no other cycle SHALL affect packet state.
REQ-015 A 32-bit free-running timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-016 The FSM SHALL have states IDLE and IN_PKT.
REQ-017 In IDLE, a transfer with enable=1 SHALL:
- capture header = link_flit[31:0], zero-extended if FLIT_WIDTH<32;
- capture timestamp = the current counter value;
- set length = 1.
- If link_last=1, the record SHALL commit and the FSM SHALL stay in IDLE; otherwise it SHALL go to IN_PKT.
REQ-018 In IDLE, a transfer with enable=0 SHALL be ignored; if link_last=0, the remaining flits of that packet SHALL be skipped (an internal skip flag SHALL be held until a transfer with link_last=1).
REQ-019 In IN_PKT, each transfer SHALL increment length, saturating at 0xFFFF; a transfer with link_last=1 SHALL commit the record and return the FSM to IDLE.
REQ-020 Once a header is accepted, changes on enable SHALL NOT affect that packet.
REQ-021 Commit SHALL push the record into the FIFO; the record SHALL appear on rec_data/rec_valid the cycle after the commit edge if the FIFO was empty.
REQ-022 rec_valid SHALL equal FIFO not-empty, and rec_data SHALL be the oldest record; a pop SHALL occur when rec_valid & rec_ready.
REQ-023 Commit with the FIFO full and no pop in the same cycle: the record SHALL be dropped.
REQ-024 Commit with the FIFO full and a pop in the same cycle: the record SHALL be accepted.
REQ-025 Simultaneous push and pop at any occupancy SHALL keep occupancy unchanged and preserve ordering.
REQ-026 rec_data SHALL remain stable while rec_valid=1 and rec_ready=0.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, without a clock:
- empty the FIFO, forcing rec_valid=0 and rec_data=0;
- set the FSM to IDLE and clear the skip flag;
- set timestamp, length, header and overflow_cnt to 0.
REQ-028 A packet in progress when reset is asserted SHALL be discarded; after reset is released, a flit that is not a header SHALL be treated as a new header.
REQ-029 The first clock edge after release SHALL see timestamp 0; it SHALL read 1 in the following cycle.

Configuration
REQ-030 With NOC_PACKET_RECORDER_OVERFLOW_CNT_EN defined:
- overflow_cnt SHALL exist;
- it SHALL increment by 1 per dropped record and saturate at 0xFFFF.
Without the macro, the port and counter SHALL be absent, and drops SHALL be silent.

Verification
REQ-031 Directed scenarios:
- After reset release, drive a 3-flit packet: header 0xCAFE0001 with first transfer at timestamp 10, transfers in cycles 10, 11, 14 with last at 14 -> one record {10, 3, 0xCAFE0001}, rec_valid=1 at cycle 15.
- Single-flit packet (valid=ready=last=1) at timestamp 5, header 0x12 -> record {5, 1, 0x12}; FSM stays in IDLE.
- link_valid=1, link_ready=0 for 4 cycles, then one transfer -> length counts 1, not 5.
- rec_ready=0 with FIFO_DEPTH=8: commit 10 packets -> 8 records held in order; overflow_cnt=2 (macro defined); then drain -> 8 records in order, rec_valid=0.
- FIFO full with commit and pop in the same cycle -> record accepted, occupancy stays 8, overflow_cnt unchanged.
- enable=0 at the header of a 4-flit packet, then enable=1 for the next packet -> only the second packet is recorded; rst_n pulsed mid-packet -> no record from that packet.
